// File: rtl/ctrl_pipe_carrier.sv
// ctrl_pipe_carrier
// -----------------
// Consumer end of the decode-stage control interface. Carries the decoder's
// per-instruction control bundles (MEM, EX, WB) through the ID/EX, EX/MEM and
// MEM/WB pipeline registers and presents each field group at the stage that
// uses it. Two-word LDM instructions are handled by parking the bundle in a
// pending register, capturing the following instruction word as the
// immediate, and inserting a bubble in the slot the LDM itself would occupy.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_mem/ex/wb      decoder control bundles for the word in decode
//   id_flush          decoder flags the current word as a two-word LDM
//   id_word           instruction word currently in decode (immediate source)
//   stall             hold decode, bubble into ID/EX
//   kill              squash decode and ID/EX, abort any pending LDM
//   ex_ctrl/ex_mem_q/ex_imm   ID/EX stage outputs
//   mem_ctrl/mem_imm          EX/MEM stage outputs
//   wb_ctrl/wb_imm            MEM/WB stage outputs
//   imm_pending       high while waiting for the LDM immediate word; this is
//                     also the FSM state (0 = RUN, 1 = IMM)
//
// Handshake: there is no valid/ready pair. Every stage register always holds
// either a real bundle or a bubble (all-zero), and a bubble writes nothing.
// stall/kill only affect what enters ID/EX; downstream stages always advance.
module ctrl_pipe_carrier #(
  parameter int DATA_W = 16,
  parameter int MEM_W  = 4,
  parameter int EX_W   = 7,
  parameter int WB_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MEM_W-1:0]  id_mem,
  input  logic [EX_W-1:0]   id_ex,
  input  logic [WB_W-1:0]   id_wb,
  input  logic              id_flush,
  input  logic [DATA_W-1:0] id_word,
  input  logic              stall,
  input  logic              kill,
  output logic [EX_W-1:0]   ex_ctrl,
  output logic [MEM_W-1:0]  ex_mem_q,
  output logic [DATA_W-1:0] ex_imm,
  output logic [MEM_W-1:0]  mem_ctrl,
  output logic [DATA_W-1:0] mem_imm,
  output logic [WB_W-1:0]   wb_ctrl,
  output logic [DATA_W-1:0] wb_imm,
  output logic              imm_pending
);

  typedef enum logic {
    S_RUN = 1'b0,
    S_IMM = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Pending LDM bundle, held while the immediate word is awaited.
  logic [MEM_W-1:0]  pend_mem_q, pend_mem_d;
  logic [EX_W-1:0]   pend_ex_q,  pend_ex_d;
  logic [WB_W-1:0]   pend_wb_q,  pend_wb_d;

  // ID/EX stage.
  logic [MEM_W-1:0]  idex_mem_q, idex_mem_d;
  logic [EX_W-1:0]   idex_ex_q,  idex_ex_d;
  logic [WB_W-1:0]   idex_wb_q,  idex_wb_d;
  logic [DATA_W-1:0] idex_imm_q, idex_imm_d;

  // EX/MEM stage (EX group consumed, MEM and WB groups carried on).
  logic [MEM_W-1:0]  exmem_mem_q;
  logic [WB_W-1:0]   exmem_wb_q;
  logic [DATA_W-1:0] exmem_imm_q;

  // MEM/WB stage.
  logic [WB_W-1:0]   memwb_wb_q;
  logic [DATA_W-1:0] memwb_imm_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: kill > stall > normal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: if (!kill && !stall && id_flush) state_d = S_IMM;
      S_IMM: if (kill || !stall)              state_d = S_RUN;
      default:                                state_d = S_RUN;
    endcase
  end

  // Output logic: what enters ID/EX and what the pending register holds.
  // In IMM the decoder bundle inputs are ignored because the word in decode
  // is the immediate, not an opcode.
  always_comb begin
    idex_mem_d  = '0;
    idex_ex_d   = '0;
    idex_wb_d   = '0;
    idex_imm_d  = '0;
    pend_mem_d  = pend_mem_q;
    pend_ex_d   = pend_ex_q;
    pend_wb_d   = pend_wb_q;
    imm_pending = (state_q == S_IMM);
    case (state_q)
      S_RUN: begin
        if (!kill && !stall) begin
          if (id_flush) begin
            pend_mem_d = id_mem;
            pend_ex_d  = id_ex;
            pend_wb_d  = id_wb;
          end else begin
            idex_mem_d = id_mem;
            idex_ex_d  = id_ex;
            idex_wb_d  = id_wb;
          end
        end
      end
      S_IMM: begin
        if (kill) begin
          pend_mem_d = '0;
          pend_ex_d  = '0;
          pend_wb_d  = '0;
        end else if (!stall) begin
          idex_mem_d = pend_mem_q;
          idex_ex_d  = pend_ex_q;
          idex_wb_d  = pend_wb_q;
          idex_imm_d = id_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mem_q <= '0;
      pend_ex_q  <= '0;
      pend_wb_q  <= '0;
      idex_mem_q <= '0;
      idex_ex_q  <= '0;
      idex_wb_q  <= '0;
      idex_imm_q <= '0;
    end else begin
      pend_mem_q <= pend_mem_d;
      pend_ex_q  <= pend_ex_d;
      pend_wb_q  <= pend_wb_d;
      idex_mem_q <= idex_mem_d;
      idex_ex_q  <= idex_ex_d;
      idex_wb_q  <= idex_wb_d;
      idex_imm_q <= idex_imm_d;
    end
  end

  // Downstream stages advance every cycle regardless of stall/kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_mem_q <= '0;
      exmem_wb_q  <= '0;
      exmem_imm_q <= '0;
      memwb_wb_q  <= '0;
      memwb_imm_q <= '0;
    end else begin
      exmem_mem_q <= idex_mem_q;
      exmem_wb_q  <= idex_wb_q;
      exmem_imm_q <= idex_imm_q;
      memwb_wb_q  <= exmem_wb_q;
      memwb_imm_q <= exmem_imm_q;
    end
  end

  assign ex_ctrl  = idex_ex_q;
  assign ex_mem_q = idex_mem_q;
  assign ex_imm   = idex_imm_q;
  assign mem_ctrl = exmem_mem_q;
  assign mem_imm  = exmem_imm_q;
  assign wb_ctrl  = memwb_wb_q;
  assign wb_imm   = memwb_imm_q;

endmodule

// File: tb/tb_ctrl_pipe_carrier.sv
// Self-checking bench for ctrl_pipe_carrier: directed scenarios with literal
// expectations plus randomized traffic, all compared every negedge against a
// behavioural model (an instruction-slot history shifted once per cycle).
module tb_ctrl_pipe_carrier;

  localparam int DATA_W = 16;
  localparam int MEM_W  = 4;
  localparam int EX_W   = 7;
  localparam int WB_W   = 3;

  localparam logic [EX_W-1:0] ADD_EX = 7'b0010101;
  localparam logic [WB_W-1:0] ADD_WB = 3'b101;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MEM_W-1:0]  id_mem = '0;
  logic [EX_W-1:0]   id_ex = '0;
  logic [WB_W-1:0]   id_wb = '0;
  logic              id_flush = 1'b0;
  logic [DATA_W-1:0] id_word = '0;
  logic              stall = 1'b0;
  logic              kill = 1'b0;

  logic [EX_W-1:0]   ex_ctrl;
  logic [MEM_W-1:0]  ex_mem_q;
  logic [DATA_W-1:0] ex_imm;
  logic [MEM_W-1:0]  mem_ctrl;
  logic [DATA_W-1:0] mem_imm;
  logic [WB_W-1:0]   wb_ctrl;
  logic [DATA_W-1:0] wb_imm;
  logic              imm_pending;

  ctrl_pipe_carrier #(
    .DATA_W(DATA_W), .MEM_W(MEM_W), .EX_W(EX_W), .WB_W(WB_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_mem(id_mem), .id_ex(id_ex), .id_wb(id_wb),
    .id_flush(id_flush), .id_word(id_word),
    .stall(stall), .kill(kill),
    .ex_ctrl(ex_ctrl), .ex_mem_q(ex_mem_q), .ex_imm(ex_imm),
    .mem_ctrl(mem_ctrl), .mem_imm(mem_imm),
    .wb_ctrl(wb_ctrl), .wb_imm(wb_imm),
    .imm_pending(imm_pending)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A slot is whatever issued into the pipe on a given edge (real or bubble).
  typedef struct packed {
    logic [MEM_W-1:0]  mem;
    logic [EX_W-1:0]   ex;
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] imm;
  } slot_t;

  slot_t s_ex = '0, s_mem = '0, s_wb = '0;   // slot issued 1, 2, 3 edges ago
  bit    waiting = 1'b0;                      // LDM seen, immediate not yet taken
  slot_t pend = '0;

  always @(posedge clk or negedge rst_n) begin
    slot_t nxt;
    if (!rst_n) begin
      s_ex = '0; s_mem = '0; s_wb = '0; waiting = 1'b0; pend = '0;
    end else begin
      nxt = '0;
      if (kill) begin
        waiting = 1'b0;
      end else if (stall) begin
        nxt = '0;
      end else if (waiting) begin
        nxt = pend;
        nxt.imm = id_word;
        waiting = 1'b0;
      end else if (id_flush) begin
        pend = '{mem: id_mem, ex: id_ex, wb: id_wb, imm: '0};
        waiting = 1'b1;
      end else begin
        nxt = '{mem: id_mem, ex: id_ex, wb: id_wb, imm: '0};
      end
      s_wb  = s_mem;
      s_mem = s_ex;
      s_ex  = nxt;
    end
  end

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    chk("ex_ctrl",  64'(ex_ctrl),     64'(s_ex.ex));
    chk("ex_mem_q", 64'(ex_mem_q),    64'(s_ex.mem));
    chk("ex_imm",   64'(ex_imm),      64'(s_ex.imm));
    chk("mem_ctrl", 64'(mem_ctrl),    64'(s_mem.mem));
    chk("mem_imm",  64'(mem_imm),     64'(s_mem.imm));
    chk("wb_ctrl",  64'(wb_ctrl),     64'(s_wb.wb));
    chk("wb_imm",   64'(wb_imm),      64'(s_wb.imm));
    chk("imm_pend", 64'(imm_pending), 64'(waiting));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MEM_W-1:0] m, input logic [EX_W-1:0] e,
                       input logic [WB_W-1:0] w, input logic f,
                       input logic [DATA_W-1:0] word, input logic st, input logic k);
    id_mem = m; id_ex = e; id_wb = w; id_flush = f; id_word = word;
    stall = st; kill = k;
  endtask

  task automatic nop();
    drive('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] all_out();
    return {15'd0, ex_ctrl, ex_mem_q, ex_imm, mem_ctrl, wb_ctrl, imm_pending} | 64'(mem_imm) | 64'(wb_imm);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset with non-zero inputs.
    drive(4'hF, 7'h7F, 3'h7, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    #23;
    chk("reset_outs_zero", all_out(), 64'd0);
    chk("reset_imm_pend",  64'(imm_pending), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD stream.
    drive(4'h0, ADD_EX, ADD_WB, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    chk("add_ex_e1", 64'(ex_ctrl), 64'(ADD_EX));
    nop();
    step();
    chk("add_mem_e2", 64'(mem_ctrl), 64'h0);
    step();
    chk("add_wb_e3", 64'(wb_ctrl), 64'(ADD_WB));
    step();
    chk("add_wb_e4_bubble", 64'(wb_ctrl), 64'h0);

    // LDM with garbage bundle on the immediate cycle.
    drive(4'b1000, 7'h0, 3'b110, 1'b1, 16'h0, 1'b0, 1'b0);
    step();
    chk("ldm_pend_e0", 64'(imm_pending), 64'd1);
    chk("ldm_ex_bubble_e0", 64'({ex_ctrl, ex_mem_q}), 64'd0);
    drive(4'b0111, 7'h7F, 3'b011, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    step();
    chk("ldm_ex_imm_e1", 64'(ex_imm), 64'hBEEF);
    chk("ldm_ex_mem_e1", 64'(ex_mem_q), 64'b1000);
    chk("ldm_ex_ctrl_e1", 64'(ex_ctrl), 64'h0);
    nop();
    step();
    step();
    chk("ldm_wb_e3", 64'(wb_ctrl), 64'b110);
    chk("ldm_wb_imm_e3", 64'(wb_imm), 64'hBEEF);
    step(); step();

    // Stall during IMM for two cycles.
    drive(4'b1000, 7'h0, 3'b110, 1'b1, 16'h0, 1'b0, 1'b0);
    step();
    drive(4'b0101, 7'h55, 3'b001, 1'b1, 16'h1234, 1'b1, 1'b0);
    step();
    chk("stall1_pend", 64'(imm_pending), 64'd1);
    chk("stall1_bubble", 64'({ex_ctrl, ex_mem_q, ex_imm}), 64'd0);
    step();
    chk("stall2_pend", 64'(imm_pending), 64'd1);
    chk("stall2_bubble", 64'({ex_ctrl, ex_mem_q, ex_imm}), 64'd0);
    stall = 1'b0;
    step();
    chk("stall_rel_imm", 64'(ex_imm), 64'h1234);
    chk("stall_rel_mem", 64'(ex_mem_q), 64'b1000);
    chk("stall_rel_pend", 64'(imm_pending), 64'd0);
    nop();
    step(); step(); step();

    // Kill during IMM, then an ADD proceeds.
    drive(4'b1000, 7'h0, 3'b110, 1'b1, 16'h0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 7'h0, 3'b000, 1'b0, 16'hDEAD, 1'b0, 1'b1);
    step();
    chk("kill_pend", 64'(imm_pending), 64'd0);
    chk("kill_bubble", 64'({ex_ctrl, ex_mem_q, ex_imm}), 64'd0);
    drive(4'h0, ADD_EX, ADD_WB, 1'b0, 16'h0, 1'b0, 1'b0);
    step();
    chk("kill_next_add", 64'(ex_ctrl), 64'(ADD_EX));
    chk("kill_next_imm", 64'(ex_imm), 64'h0);
    nop();
    step(); step(); step();

    // Async reset mid-pipeline with three ADDs in flight.
    drive(4'h0, ADD_EX, ADD_WB, 1'b0, 16'h0, 1'b0, 1'b0);
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("areset_outs_zero", all_out(), 64'd0);
    #1 rst_n = 1'b1;

    // Async reset with a pending LDM clears pend.
    drive(4'b1000, 7'h0, 3'b110, 1'b1, 16'h0, 1'b0, 1'b0);
    step();
    chk("areset_ldm_pend", 64'(imm_pending), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_pend_clear", 64'(imm_pending), 64'd0);
    #1 rst_n = 1'b1;
    drive(4'h0, ADD_EX, ADD_WB, 1'b0, 16'h7777, 1'b0, 1'b0);
    step();
    chk("areset_after_ex", 64'(ex_ctrl), 64'(ADD_EX));
    chk("areset_after_imm", 64'(ex_imm), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(4'($urandom), 7'($urandom), 3'($urandom),
            ($urandom_range(0, 3) == 0), 16'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      step();
    end
    nop();
    step(); step(); step();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_carrier.md
Name: ctrl_pipe_carrier

Overview:
- Consumer end of the decode-stage control interface.
- Takes the decoder's per-instruction control bundles (MEM 4b, EX 7b, WB 3b) and its two-word flag `flush`.
- Carries each bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers and presents each field group at the stage that uses it.
- Handles two-word LDM: captures the following instruction word as the immediate and inserts a bubble in its place. Handles stall and pipeline-kill.

Parameters:
- DATA_W, 16, instruction word / immediate width
- MEM_W, 4, MEM bundle width {memRead, memWrite, memAddress, memData}
- EX_W, 7, EX bundle width {ALUop+enable(5), shamSel(1), flag_en(1)}
- WB_W, 3, WB bundle width {regWrite(1), WBsel(2)}

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_mem  in  MEM_W  decoder MEM bundle
- id_ex  in  EX_W  decoder EX bundle
- id_wb  in  WB_W  decoder WB bundle
- id_flush  in  1  decoder: current instruction is two-word (LDM)
- id_word  in  DATA_W  instruction word currently in decode
- stall  in  1  hazard unit: hold decode, bubble into ID/EX
- kill  in  1  squash decode and ID/EX contents, abort pending LDM
- ex_ctrl  out  EX_W  ID/EX EX bundle
- ex_mem_q  out  MEM_W  ID/EX MEM bundle (forwarded to EX/MEM)
- ex_imm  out  DATA_W  ID/EX immediate
- mem_ctrl  out  MEM_W  EX/MEM MEM bundle
- mem_imm  out  DATA_W  EX/MEM immediate
- wb_ctrl  out  WB_W  MEM/WB WB bundle
- wb_imm  out  DATA_W  MEM/WB immediate
- imm_pending  out  1  high while in IMM state; fetch must not treat id_word as an opcode

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low on rst_n.
  - Reset drives every stage register to a bubble: EX=0, MEM=0, WB=000, imm=0.
  - Reset also clears pend (bundle and imm) and sets state=RUN, imm_pending=0.
  - Reset asserted mid-LDM discards the pending LDM.
- Bubble: EX=0, MEM=0, WB=000, imm=0. A bubble writes no register and no memory.
- Each stage register passes all downstream field groups along. The WB group rides ID/EX and EX/MEM internally.
- Latency from decode to output:
  - ex_* valid 1 cycle after decode.
  - mem_* valid after 2 cycles.
  - wb_* valid after 3 cycles.
  - LDM adds 1 cycle, for the immediate.
- EX/MEM <= ID/EX and MEM/WB <= EX/MEM every cycle. Stall and kill never freeze them.
- State machine, 2 states, evaluated at each rising edge, priority kill > stall > normal:
  - RUN, kill=1: ID/EX <= bubble; stay RUN.
  - RUN, stall=1: ID/EX <= bubble; stay RUN (decoder output is re-presented next cycle).
  - RUN, id_flush=1: pend <= {id_mem,id_ex,id_wb}; ID/EX <= bubble; go IMM.
  - RUN, otherwise: ID/EX <= {id_mem,id_ex,id_wb, imm=0}.
  - IMM, kill=1: pend discarded; ID/EX <= bubble; go RUN.
  - IMM, stall=1: ID/EX <= bubble; hold pend; stay IMM (fetch holds id_word).
  - IMM, otherwise: ID/EX <= {pend, imm=id_word}; go RUN.
  - In IMM, id_mem/id_ex/id_wb/id_flush are ignored, because the decoder sees the immediate as an opcode.
- imm_pending = (state==IMM), combinational from the state register.
- Back-to-back LDM: the cycle after leaving IMM is RUN, so an LDM there is accepted normally. There is no extra gap.
- The carrier does not modify bundle contents except for bubble insertion. Don't-care WB bits on stores pass through unchanged; benches drive defined values.

Test Plan:
- Reset: hold rst_n=0 with non-zero inputs -> all outputs 0, imm_pending=0. Release -> first real bundle appears on ex_ctrl after 1 edge.
- ADD stream: drive id_ex=7'b0010101, id_wb=3'b101 for 1 cycle, then NOP bundles -> ex_ctrl=0010101 at edge 1, mem_ctrl=0000 at edge 2, wb_ctrl=101 at edge 3; bubbles follow.
- LDM: cycle0 id_flush=1, id_mem=4'b1000, id_wb=3'b110; cycle1 id_word=16'hBEEF with a garbage bundle. Required response:
  - imm_pending=1 after edge 0.
  - ex_ctrl shows a bubble after edge 0.
  - After edge 1: ex_imm=BEEF, ex_mem_q=1000.
  - wb_ctrl=110 and wb_imm=BEEF after edge 3.
  - The garbage bundle never appears.
- Stall during IMM: LDM, then stall=1 for 2 cycles with id_word=16'h1234 -> imm_pending stays 1, 2 bubbles enter ID/EX. Release -> ex_imm=1234 with the LDM bundle.
- Kill during IMM: LDM, then kill=1 -> state RUN, ID/EX bubble, LDM bundle never reaches wb_ctrl. The next ADD proceeds normally.
- Async reset mid-pipeline: three ADD bundles in flight, pulse rst_n low between edges -> all outputs 0 immediately without waiting for a clock edge; pend cleared.
